// File: rtl/board_mem_arbiter_if.sv
// Signal bundle between board_mem_arbiter, its three requesters and the board memory.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface board_mem_arbiter_if #(
    parameter int AW     = 7,
    parameter int CELL_W = 4
) ();
    logic              vga_req;
    logic [AW-1:0]     vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [CELL_W-1:0] vga_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [CELL_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [CELL_W-1:0] cpu_rdata;

    logic              uart_req;
    logic              uart_we;
    logic [AW-1:0]     uart_addr;
    logic [CELL_W-1:0] uart_wdata;
    logic              uart_gnt;
    logic              uart_rvalid;
    logic [CELL_W-1:0] uart_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [CELL_W-1:0] mem_wdata;
    logic [CELL_W-1:0] mem_rdata;

    logic              addr_err;

    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  uart_req, uart_we, uart_addr, uart_wdata,
        input  mem_rdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output uart_gnt, uart_rvalid, uart_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output addr_err
    );

    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output uart_req, uart_we, uart_addr, uart_wdata,
        output mem_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  uart_gnt, uart_rvalid, uart_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  addr_err
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Arbiter sharing the 1-cycle-latency board memory between VGA (fixed priority), CPU and UART.
// Define BOARD_ARB_STATS_EN to add saturating grant and VGA-preemption counters.
module board_mem_arbiter #(
    parameter int ROWS         = 10,
    parameter int COLS         = 10,
    parameter int CELL_W       = 4,
    parameter int AW           = 7,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    board_mem_arbiter_if.slave bus
`ifdef BOARD_ARB_STATS_EN
    ,
    output logic [15:0]        vga_cnt,
    output logic [15:0]        cpu_cnt,
    output logic [15:0]        uart_cnt,
    output logic [15:0]        preempt_cnt
`endif
);

    localparam int              AW1        = AW + 1;
    localparam logic [AW:0]     CELLS_LIM  = AW1'(ROWS * COLS);
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        RR_CPU,
        RR_UART
    } rr_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_VGA,
        SRC_CPU,
        SRC_UART
    } src_e;

    rr_e               rr_q, rr_d;
    logic [SW-1:0]     starve_q, starve_d;
    src_e              tag_q, tag_d;
    logic              tag_oor_q, tag_oor_d;
    logic              addr_err_q, addr_err_d;
    logic [CELL_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [CELL_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [CELL_W-1:0] uart_rdata_q, uart_rdata_d;

    src_e              gnt_src;
    src_e              rr_pick;
    logic              any_rr;
    logic              starved;
    logic              granted;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [CELL_W-1:0] sel_wdata;
    logic              sel_oor;
    logic [CELL_W-1:0] ret_data;

    // Grant selection, memory mux and next-state for pointer, starve counter and read tag.
    // Grants are forced off while reset is asserted so the bus is quiet during reset.
    always_comb begin
        gnt_src   = SRC_NONE;
        any_rr    = bus.cpu_req | bus.uart_req;
        starved   = (starve_q == STARVE_MAX);
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;

        if (rr_q == RR_CPU) begin
            rr_pick = bus.cpu_req ? SRC_CPU : SRC_UART;
        end else begin
            rr_pick = bus.uart_req ? SRC_UART : SRC_CPU;
        end

        if (rst) begin
            if (starved && any_rr) begin
                gnt_src = rr_pick;
            end else if (bus.vga_req) begin
                gnt_src = SRC_VGA;
            end else if (any_rr) begin
                gnt_src = rr_pick;
            end
        end

        unique case (gnt_src)
            SRC_VGA: begin
                sel_addr = bus.vga_addr;
            end
            SRC_CPU: begin
                sel_we    = bus.cpu_we;
                sel_addr  = bus.cpu_addr;
                sel_wdata = bus.cpu_wdata;
            end
            SRC_UART: begin
                sel_we    = bus.uart_we;
                sel_addr  = bus.uart_addr;
                sel_wdata = bus.uart_wdata;
            end
            default: begin
            end
        endcase

        granted = (gnt_src != SRC_NONE);
        sel_oor = ({1'b0, sel_addr} >= CELLS_LIM);

        bus.vga_gnt   = (gnt_src == SRC_VGA);
        bus.cpu_gnt   = (gnt_src == SRC_CPU);
        bus.uart_gnt  = (gnt_src == SRC_UART);
        bus.mem_en    = granted & ~sel_oor;
        bus.mem_we    = granted & ~sel_oor & sel_we;
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
        bus.addr_err  = addr_err_q;

        rr_d = rr_q;
        if (gnt_src == SRC_CPU) begin
            rr_d = RR_UART;
        end else if (gnt_src == SRC_UART) begin
            rr_d = RR_CPU;
        end

        if ((gnt_src == SRC_CPU) || (gnt_src == SRC_UART) || !any_rr) begin
            starve_d = '0;
        end else if (starved) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + SW'(1);
        end

        tag_d      = (granted && !sel_we) ? gnt_src : SRC_NONE;
        tag_oor_d  = sel_oor;
        addr_err_d = addr_err_q | (granted & sel_oor);
    end

    // Read return: the tag raised at grant steers mem_rdata (or zero for out-of-range) to one requester.
    always_comb begin
        ret_data = tag_oor_q ? '0 : bus.mem_rdata;

        bus.vga_rvalid  = rst && (tag_q == SRC_VGA);
        bus.cpu_rvalid  = rst && (tag_q == SRC_CPU);
        bus.uart_rvalid = rst && (tag_q == SRC_UART);

        vga_rdata_d  = bus.vga_rvalid  ? ret_data : vga_rdata_q;
        cpu_rdata_d  = bus.cpu_rvalid  ? ret_data : cpu_rdata_q;
        uart_rdata_d = bus.uart_rvalid ? ret_data : uart_rdata_q;

        bus.vga_rdata  = rst ? vga_rdata_d  : '0;
        bus.cpu_rdata  = rst ? cpu_rdata_d  : '0;
        bus.uart_rdata = rst ? uart_rdata_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q         <= RR_CPU;
            starve_q     <= '0;
            tag_q        <= SRC_NONE;
            tag_oor_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            uart_rdata_q <= '0;
        end else begin
            rr_q         <= rr_d;
            starve_q     <= starve_d;
            tag_q        <= tag_d;
            tag_oor_q    <= tag_oor_d;
            addr_err_q   <= addr_err_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            uart_rdata_q <= uart_rdata_d;
        end
    end

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] vga_cnt_q, vga_cnt_d;
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] uart_cnt_q, uart_cnt_d;
    logic [15:0] preempt_cnt_q, preempt_cnt_d;
    logic        preempt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // A preemption is a starved CPU/UART grant taken while VGA was also asking.
    always_comb begin
        preempt       = rst & starved & any_rr & bus.vga_req;
        vga_cnt_d     = sat_inc(vga_cnt_q, bus.vga_gnt);
        cpu_cnt_d     = sat_inc(cpu_cnt_q, bus.cpu_gnt);
        uart_cnt_d    = sat_inc(uart_cnt_q, bus.uart_gnt);
        preempt_cnt_d = sat_inc(preempt_cnt_q, preempt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_cnt_q     <= '0;
            cpu_cnt_q     <= '0;
            uart_cnt_q    <= '0;
            preempt_cnt_q <= '0;
        end else begin
            vga_cnt_q     <= vga_cnt_d;
            cpu_cnt_q     <= cpu_cnt_d;
            uart_cnt_q    <= uart_cnt_d;
            preempt_cnt_q <= preempt_cnt_d;
        end
    end

    assign vga_cnt     = vga_cnt_q;
    assign cpu_cnt     = cpu_cnt_q;
    assign uart_cnt    = uart_cnt_q;
    assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: behavioural arbiter model plus shadow board,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_board_mem_arbiter;

    localparam int ROWS         = 10;
    localparam int COLS         = 10;
    localparam int CELL_W       = 4;
    localparam int AW           = 7;
    localparam int STARVE_LIMIT = 8;
    localparam int CELLS        = ROWS * COLS;

    localparam int W_NONE = 0;
    localparam int W_VGA  = 1;
    localparam int W_CPU  = 2;
    localparam int W_UART = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   checkEn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    board_mem_arbiter_if #(.AW(AW), .CELL_W(CELL_W)) bus ();

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] vga_cnt, cpu_cnt, uart_cnt, preempt_cnt;
`endif

    board_mem_arbiter #(
        .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BOARD_ARB_STATS_EN
        ,
        .vga_cnt(vga_cnt),
        .cpu_cnt(cpu_cnt),
        .uart_cnt(uart_cnt),
        .preempt_cnt(preempt_cnt)
`endif
    );

    // Board memory: one-cycle read latency, junk on the read bus whenever no read happened.
    logic [CELL_W-1:0] boardMem [0:127];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            boardMem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= CELL_W'($urandom);
        end else if (bus.mem_en) begin
            bus.mem_rdata <= boardMem[bus.mem_addr];
        end else begin
            bus.mem_rdata <= CELL_W'($urandom);
        end
    end

    // Reference model state
    int                m_rr;
    int                m_starve;
    int                m_pend;
    logic [CELL_W-1:0] m_pendData;
    bit                m_err;
    logic [CELL_W-1:0] m_hold [4];
    logic [CELL_W-1:0] shadow [0:127];
    int                m_cnt [4];
    int                m_preempt;

    function automatic int reqAddr(input int who);
        if (who == W_VGA)  return int'(bus.vga_addr);
        if (who == W_CPU)  return int'(bus.cpu_addr);
        if (who == W_UART) return int'(bus.uart_addr);
        return 0;
    endfunction

    function automatic bit reqWe(input int who);
        if (who == W_CPU)  return bus.cpu_we;
        if (who == W_UART) return bus.uart_we;
        return 1'b0;
    endfunction

    function automatic int reqWdata(input int who);
        if (who == W_CPU)  return int'(bus.cpu_wdata);
        if (who == W_UART) return int'(bus.uart_wdata);
        return 0;
    endfunction

    function automatic int predictWho();
        bit anyRr;
        int pick;
        if (rst !== 1'b1) return W_NONE;
        anyRr = bus.cpu_req || bus.uart_req;
        if (m_rr == W_CPU) pick = bus.cpu_req ? W_CPU : W_UART;
        else               pick = bus.uart_req ? W_UART : W_CPU;
        if (anyRr && m_starve >= STARVE_LIMIT) return pick;
        if (bus.vga_req) return W_VGA;
        if (anyRr) return pick;
        return W_NONE;
    endfunction

    // Model state advance at each clock edge
    always @(posedge clk) begin
        int who;
        int a;
        bit oor;
        if (rst !== 1'b1) begin
            m_rr = W_CPU;
            m_starve = 0;
            m_pend = W_NONE;
            m_pendData = '0;
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_hold[i] = '0;
                m_cnt[i] = 0;
            end
            m_preempt = 0;
        end else begin
            who = predictWho();
            if (m_pend != W_NONE) m_hold[m_pend] = m_pendData;
            m_pend = W_NONE;
            if (who != W_NONE) begin
                a = reqAddr(who);
                oor = (a >= CELLS);
                if (oor) m_err = 1'b1;
                if (!reqWe(who)) begin
                    m_pend = who;
                    m_pendData = oor ? '0 : shadow[a];
                end else if (!oor) begin
                    shadow[a] = CELL_W'(reqWdata(who));
                end
                if (m_cnt[who] < 65535) m_cnt[who]++;
                if (who != W_VGA && bus.vga_req && m_starve >= STARVE_LIMIT && m_preempt < 65535)
                    m_preempt++;
                if (who == W_CPU)  m_rr = W_UART;
                if (who == W_UART) m_rr = W_CPU;
            end
            if (who == W_CPU || who == W_UART || !(bus.cpu_req || bus.uart_req)) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkCycle();
        int who;
        bit expEn;
        who = predictWho();
        expEn = (who != W_NONE) && (reqAddr(who) < CELLS);
        checkOutput("vga_gnt", bus.vga_gnt, who == W_VGA);
        checkOutput("cpu_gnt", bus.cpu_gnt, who == W_CPU);
        checkOutput("uart_gnt", bus.uart_gnt, who == W_UART);
        checkOutput("mem_en", bus.mem_en, expEn);
        if (expEn) begin
            checkOutput("mem_we", bus.mem_we, reqWe(who));
            checkOutput("mem_addr", bus.mem_addr, reqAddr(who));
            if (reqWe(who)) checkOutput("mem_wdata", bus.mem_wdata, reqWdata(who));
        end
        if (rst !== 1'b1) begin
            checkOutput("rst_mem_we", bus.mem_we, 0);
            checkOutput("rst_mem_addr", bus.mem_addr, 0);
            checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        end
        checkOutput("vga_rvalid", bus.vga_rvalid, rst && m_pend == W_VGA);
        checkOutput("cpu_rvalid", bus.cpu_rvalid, rst && m_pend == W_CPU);
        checkOutput("uart_rvalid", bus.uart_rvalid, rst && m_pend == W_UART);
        checkOutput("vga_rdata", bus.vga_rdata, !rst ? 0 : (m_pend == W_VGA ? m_pendData : m_hold[W_VGA]));
        checkOutput("cpu_rdata", bus.cpu_rdata, !rst ? 0 : (m_pend == W_CPU ? m_pendData : m_hold[W_CPU]));
        checkOutput("uart_rdata", bus.uart_rdata, !rst ? 0 : (m_pend == W_UART ? m_pendData : m_hold[W_UART]));
        checkOutput("addr_err", bus.addr_err, m_err);
`ifdef BOARD_ARB_STATS_EN
        checkOutput("vga_cnt", vga_cnt, m_cnt[W_VGA]);
        checkOutput("cpu_cnt", cpu_cnt, m_cnt[W_CPU]);
        checkOutput("uart_cnt", uart_cnt, m_cnt[W_UART]);
        checkOutput("preempt_cnt", preempt_cnt, m_preempt);
`endif
    endtask

    // Compare process: DUT outputs against the model every cycle, mid low phase.
    always @(negedge clk) begin
        #2;
        if (checkEn) checkCycle();
    end

    task automatic applyStimulus(input bit vr, input int va,
                                 input bit cr, input bit cw, input int ca, input int cd,
                                 input bit ur, input bit uw, input int ua, input int ud);
        @(negedge clk);
        bus.vga_req    = vr;
        bus.vga_addr   = AW'(va);
        bus.cpu_req    = cr;
        bus.cpu_we     = cw;
        bus.cpu_addr   = AW'(ca);
        bus.cpu_wdata  = CELL_W'(cd);
        bus.uart_req   = ur;
        bus.uart_we    = uw;
        bus.uart_addr  = AW'(ua);
        bus.uart_wdata = CELL_W'(ud);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        idleCycle();
        rst = 1'b0;
        idleCycle();
        idleCycle();
        rst = 1'b1;
    endtask

    initial begin
        bus.vga_req = 0; bus.vga_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.uart_req = 0; bus.uart_we = 0; bus.uart_addr = '0; bus.uart_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            boardMem[i] = CELL_W'($urandom);
            shadow[i] = boardMem[i];
        end

        // Hold reset for two edges before enabling the model comparison
        rst = 1'b0;
        idleCycle();
        idleCycle();
        checkEn = 1'b1;
        idleCycle();
        rst = 1'b1;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            idleCycle();
            #3;
            checkOutput("idle_gnts", {bus.vga_gnt, bus.cpu_gnt, bus.uart_gnt, bus.mem_en}, 0);
            checkOutput("idle_rvalids", {bus.vga_rvalid, bus.cpu_rvalid, bus.uart_rvalid}, 0);
            checkOutput("idle_addr_err", bus.addr_err, 0);
        end

        // CPU write then read back cell 44
        applyStimulus(0, 0, 1, 1, 44, 5, 0, 0, 0, 0);
        #3;
        checkOutput("wr44_gnt", bus.cpu_gnt, 1);
        checkOutput("wr44_mem_we", bus.mem_we, 1);
        applyStimulus(0, 0, 1, 0, 44, 0, 0, 0, 0, 0);
        #3;
        checkOutput("rd44_gnt", bus.cpu_gnt, 1);
        idleCycle();
        #3;
        checkOutput("rd44_rvalid", bus.cpu_rvalid, 1);
        checkOutput("rd44_rdata", bus.cpu_rdata, 4'h5);
        checkOutput("rd44_other_rvalid", {bus.vga_rvalid, bus.uart_rvalid}, 0);

        // CPU and UART both reading from reset: alternation
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1, 0, 10 + k, 0, 1, 0, 20 + k, 0);
            #3;
            checkOutput("rr_cpu_gnt", bus.cpu_gnt, (k % 2) == 0);
            checkOutput("rr_uart_gnt", bus.uart_gnt, (k % 2) == 1);
            if (k > 0) checkOutput("rr_cpu_rvalid", bus.cpu_rvalid, ((k - 1) % 2) == 0);
        end
        idleCycle();
        #3;
        checkOutput("rr_last_uart_rvalid", bus.uart_rvalid, 1);

        // VGA back-to-back with a CPU request: preempted after the starve limit
        doReset();
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 30 + k, k <= 8, 0, 7, 0, 0, 0, 0, 0);
            #3;
            checkOutput("starve_vga_gnt", bus.vga_gnt, k != 8);
            checkOutput("starve_cpu_gnt", bus.cpu_gnt, k == 8);
        end
`ifdef BOARD_ARB_STATS_EN
        checkOutput("starve_preempt_cnt", preempt_cnt, 1);
`endif

        // Out-of-range UART read, then sticky error flag
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 100, 0);
        #3;
        checkOutput("oor_uart_gnt", bus.uart_gnt, 1);
        checkOutput("oor_mem_en", bus.mem_en, 0);
        applyStimulus(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
        #3;
        checkOutput("oor_uart_rvalid", bus.uart_rvalid, 1);
        checkOutput("oor_uart_rdata", bus.uart_rdata, 0);
        checkOutput("oor_addr_err", bus.addr_err, 1);
        idleCycle();
        #3;
        checkOutput("oor_addr_err_sticky", bus.addr_err, 1);

        // Reset while a CPU read is in flight
        applyStimulus(0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
        idleCycle();
        rst = 1'b0;
        #3;
        checkOutput("rstmid_cpu_rvalid", bus.cpu_rvalid, 0);
        idleCycle();
        applyStimulus(0, 0, 1, 0, 6, 0, 1, 0, 7, 0);
        rst = 1'b1;
        #3;
        checkOutput("rstmid_cpu_first", bus.cpu_gnt, 1);
        checkOutput("rstmid_addr_err", bus.addr_err, 0);

        // Randomized traffic with varying VGA pressure and rare resets
        for (int k = 0; k < 3000; k++) begin
            int vgaPct;
            int ca, ua, va;
            vgaPct = ((k / 500) % 3 == 0) ? 20 : (((k / 500) % 3 == 1) ? 60 : 95);
            va = ($urandom_range(0, 29) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
            ca = ($urandom_range(0, 29) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
            ua = ($urandom_range(0, 29) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
            applyStimulus($urandom_range(0, 99) < vgaPct, va,
                          $urandom_range(0, 1), $urandom_range(0, 99) < 40, ca, $urandom,
                          $urandom_range(0, 1), $urandom_range(0, 99) < 40, ua, $urandom);
            rst = ($urandom_range(0, 299) != 0);
        end
        idleCycle();
        rst = 1'b1;
        idleCycle();
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
